// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode/funct7 constants, ALU opcode encoding and decode-stage states.
package rv_pkg;
    localparam logic [6:0] OP      = 7'h33;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] LUI     = 7'h37;
    localparam logic [6:0] AUIPC   = 7'h17;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRA  = 4'hD
    } alu_op_t;

    typedef enum logic {RUN, HALT} dec_state_t;
endpackage

// File: rtl/alu_decode_imm_gen.sv
// imm_gen: combinational I-type, shift-amount and U-type immediate extraction.
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_sh,
    output logic [31:0] imm_u
);
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_sh = {27'd0, instr[24:20]};
    assign imm_u  = {instr[31:12], 12'd0};
endmodule

// File: rtl/alu_decode.sv
// alu_decode: RV32I decode/issue stage for OP, OP-IMM, LUI and AUIPC feeding the integer ALU.
// Illegal encodings halt the stage until clear.
module alu_decode
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        illegal,
    output logic [31:0] illegal_pc,
    input  logic        clear
);
    dec_state_t  state;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        shift, legal, accept;
    logic [3:0]  d_op;
    logic [31:0] d_a, d_b, imm_i, imm_sh, imm_u;

    imm_gen u_imm (.instr(in_instr), .imm_i(imm_i), .imm_sh(imm_sh), .imm_u(imm_u));

    assign opcode   = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign shift    = f3 == 3'd1 || f3 == 3'd5;
    assign in_ready = state == RUN && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        legal = 1'b0;
        d_op  = ALU_ADD;
        d_a   = rs1_data;
        d_b   = rs2_data;
        case (opcode)
            OP: begin
                legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5));
                d_op  = {in_instr[30], f3};
            end
            OP_IMM: begin
                // only shifts carry the arithmetic bit; other immediates reuse instr[30] as data
                legal = !shift || f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'd5);
                d_op  = {shift & in_instr[30], f3};
                d_b   = shift ? imm_sh : imm_i;
            end
            LUI: begin
                legal = 1'b1;
                d_a   = '0;
                d_b   = imm_u;
            end
            AUIPC: begin
                legal = 1'b1;
                d_a   = in_pc;
                d_b   = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            alu_op     <= ALU_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_addr    <= '0;
            rd_we      <= 1'b0;
            illegal    <= 1'b0;
            illegal_pc <= '0;
        end else begin
            if (accept && legal) begin
                out_valid <= 1'b1;
                alu_op    <= d_op;
                alu_a     <= d_a;
                alu_b     <= d_b;
                rd_addr   <= in_instr[11:7];
                rd_we     <= |in_instr[11:7];
            end else if (accept || out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !legal) begin
                state      <= HALT;
                illegal    <= 1'b1;
                illegal_pc <= in_pc;
            end else if (state == HALT && clear) begin
                state   <= RUN;
                illegal <= 1'b0;
            end
        end
    end
endmodule
